// File: rtl/uart_frame_tx.sv
// Transmit framer: snapshots generator settings and streams them as a byte frame
// over a ready/valid sink. Optional checksum byte enabled by UART_TX_CHECKSUM_EN.
module uart_frame_tx #(
    parameter logic [7:0] SOM = 8'h73,
    parameter logic [7:0] EOM = 8'h65
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        send,
    input  logic [7:0]  signal_number,
    input  logic [31:0] adder,
    input  logic [31:0] amplitude,
    output logic        busy,
    output logic        done,
    output logic [7:0]  to_uart_data,
    output logic        to_uart_valid,
    input  logic        to_uart_ready
);

`ifdef UART_TX_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd11;
`else
    localparam logic [3:0] LAST_IDX = 4'd10;
`endif

    typedef enum logic {IDLE, SEND} state_e;

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  sig_q, sig_d;
    logic [31:0] adder_q, adder_d;
    logic [31:0] amp_q, amp_d;
    logic        done_q, done_d;
    logic [7:0]  byte_sel;

`ifdef UART_TX_CHECKSUM_EN
    logic [7:0] csum;
    assign csum = sig_q
                ^ adder_q[31:24] ^ adder_q[23:16] ^ adder_q[15:8] ^ adder_q[7:0]
                ^ amp_q[31:24]   ^ amp_q[23:16]   ^ amp_q[15:8]   ^ amp_q[7:0];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sig_q   <= '0;
            adder_q <= '0;
            amp_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sig_q   <= sig_d;
            adder_q <= adder_d;
            amp_q   <= amp_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sig_d   = sig_q;
        adder_d = adder_q;
        amp_d   = amp_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (send) begin
                    sig_d   = signal_number;
                    adder_d = adder;
                    amp_d   = amplitude;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                // Shadows stay frozen here, so a send during a frame is simply dropped.
                if (to_uart_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_sel = 8'h00;
        case (idx_q)
            4'd0:  byte_sel = SOM;
            4'd1:  byte_sel = sig_q;
            4'd2:  byte_sel = adder_q[31:24];
            4'd3:  byte_sel = adder_q[23:16];
            4'd4:  byte_sel = adder_q[15:8];
            4'd5:  byte_sel = adder_q[7:0];
            4'd6:  byte_sel = amp_q[31:24];
            4'd7:  byte_sel = amp_q[23:16];
            4'd8:  byte_sel = amp_q[15:8];
            4'd9:  byte_sel = amp_q[7:0];
`ifdef UART_TX_CHECKSUM_EN
            4'd10: byte_sel = csum;
            4'd11: byte_sel = EOM;
`else
            4'd10: byte_sel = EOM;
`endif
            default: byte_sel = 8'h00;
        endcase
    end

    always_comb begin
        busy          = (state_q == SEND);
        to_uart_valid = (state_q == SEND);
        to_uart_data  = (state_q == SEND) ? byte_sel : 8'h00;
        done          = done_q;
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed self-checking bench for uart_frame_tx; follows UART_TX_CHECKSUM_EN
// to select the expected frame layout.
module tb_uart_frame_tx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        send;
    logic [7:0]  signal_number;
    logic [31:0] adder;
    logic [31:0] amplitude;
    logic        busy;
    logic        done;
    logic [7:0]  to_uart_data;
    logic        to_uart_valid;
    logic        to_uart_ready;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    int         done_cnt;

    always #5 clk = ~clk;

    uart_frame_tx #(.SOM(8'h73), .EOM(8'h65)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .send          (send),
        .signal_number (signal_number),
        .adder         (adder),
        .amplitude     (amplitude),
        .busy          (busy),
        .done          (done),
        .to_uart_data  (to_uart_data),
        .to_uart_valid (to_uart_valid),
        .to_uart_ready (to_uart_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Runs after send has been raised; samples #1 after each edge, records bytes
    // that will transfer on the next edge, and stops 14 cycles after the first done.
    task automatic collect(input bit rnd, input bit mid_send, input bit send_on_done,
                           output int first_done, output int second_done);
        logic [7:0] pat = 8'b1101_1001;
        logic [7:0] prev_d = 8'h00;
        bit         prev_stall = 1'b0;
        bit         injected = 1'b0;
        bit         som_next = 1'b0;
        got.delete();
        done_cnt    = 0;
        first_done  = -1;
        second_done = -1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clk); #1;
            send = 1'b0;
            if (prev_stall) begin
                check("hold_valid", {31'd0, to_uart_valid}, 32'd1);
                check("hold_data", {24'd0, to_uart_data}, {24'd0, prev_d});
            end
            if (som_next) begin
                check("b2b_valid", {31'd0, to_uart_valid}, 32'd1);
                check("b2b_som", {24'd0, to_uart_data}, 32'h73);
                som_next = 1'b0;
            end
            if (done) begin
                done_cnt++;
                if (first_done < 0) begin
                    first_done = cyc;
                    check("busy_in_done", {31'd0, busy}, 32'd0);
                    check("valid_in_done", {31'd0, to_uart_valid}, 32'd0);
                    if (send_on_done) begin
                        send     = 1'b1;
                        som_next = 1'b1;
                    end
                end else if (second_done < 0) begin
                    second_done = cyc;
                end
            end
            if (mid_send && !injected && got.size() == 3) begin
                adder    = 32'hDEADBEEF;
                send     = 1'b1;
                injected = 1'b1;
            end
            to_uart_ready = rnd ? pat[cyc % 8] : 1'b1;
            if (to_uart_valid && to_uart_ready) got.push_back(to_uart_data);
            prev_stall = to_uart_valid && !to_uart_ready;
            prev_d     = to_uart_data;
            if (first_done > 0 && cyc >= first_done + 14) break;
        end
        send = 1'b0;
    endtask

    task automatic start_frame();
        @(posedge clk); #1;
        send = 1'b1;
    endtask

    task automatic check_frame(input string tag, input int base);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got.size())
                check($sformatf("%s_byte%0d", tag, i), {24'd0, got[base + i]}, {24'd0, exp_q[i]});
            else
                check($sformatf("%s_missing%0d", tag, i), 32'd0, 32'd1);
        end
    endtask

    initial begin
        int fd, sd, n, guard, vcnt;
        int flen;
        reset_n       = 1'b0;
        send          = 1'b0;
        to_uart_ready = 1'b1;
        signal_number = 8'h02;
        adder         = 32'h12345678;
        amplitude     = 32'h000000FF;

        exp_q = '{8'h73, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'hFF};
`ifdef UART_TX_CHECKSUM_EN
        // 02^12^34^56^78^00^00^00^FF
        exp_q.push_back(8'hF5);
`endif
        exp_q.push_back(8'h65);
        flen = exp_q.size();

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_valid", {31'd0, to_uart_valid}, 32'd0);
        check("rst_data", {24'd0, to_uart_data}, 32'h00);
        reset_n = 1'b1;

        // Basic frame, ready held high
        start_frame();
        collect(1'b0, 1'b0, 1'b0, fd, sd);
        check("t1_latency", fd, flen + 1);
        check("t1_len", got.size(), flen);
        check("t1_dones", done_cnt, 1);
        check_frame("t1", 0);

        // Ready toggling
        start_frame();
        collect(1'b1, 1'b0, 1'b0, fd, sd);
        check("t2_done_seen", {31'd0, fd > 0}, 32'd1);
        check("t2_len", got.size(), flen);
        check("t2_dones", done_cnt, 1);
        check_frame("t2", 0);

        // Input change plus ignored send mid-frame
        start_frame();
        collect(1'b0, 1'b1, 1'b0, fd, sd);
        check("t3_len", got.size(), flen);
        check("t3_dones", done_cnt, 1);
        check_frame("t3", 0);
        adder = 32'h12345678;

        // Send in the done cycle starts the next frame immediately
        start_frame();
        collect(1'b0, 1'b0, 1'b1, fd, sd);
        check("t4_len", got.size(), 2 * flen);
        check("t4_dones", done_cnt, 2);
        check("t4_gap", sd - fd, flen + 1);
        check_frame("t4a", 0);
        check_frame("t4b", flen);

        // Asynchronous reset after the 5th byte
        start_frame();
        @(posedge clk); #1;
        send  = 1'b0;
        n     = 0;
        guard = 0;
        while (n < 5 && guard < 50) begin
            if (to_uart_valid && to_uart_ready) n++;
            @(posedge clk); #1;
            guard++;
        end
        check("t5_five_sent", n, 5);
        check("t5_pre_valid", {31'd0, to_uart_valid}, 32'd1);
        check("t5_pre_data", {24'd0, to_uart_data}, {24'd0, exp_q[5]});
        #2 reset_n = 1'b0;
        #1;
        check("t5_valid", {31'd0, to_uart_valid}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        vcnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (to_uart_valid || busy || done) vcnt++;
        end
        check("t5_idle_after", vcnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
